// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: takes one event from EX, writes the trap CSRs, then redirects fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic        interrupt_pending,
    input  logic        mie,
    input  logic [31:0] interrupt_cause,
    input  logic        ecall_in,
    input  logic        ebreak_in,
    input  logic        mret_in,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        mpie,
    output logic        csr_trap_we,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic        mstatus_we,
    output logic        mie_next,
    output logic        mpie_next,
    output logic        stall_pipeline,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_addr,
    output logic        flush_pipeline,
    output logic [15:0] trap_count
);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] target_q, target_d;
    logic        mieSampled_q, mieSampled_d;
    logic [15:0] count_q, count_d;

    logic        takeIrq;
    logic [31:0] trapBase;
    logic [31:0] irqTarget;
    logic        csrWe, mstatusWe, mieNext, mpieNext, stall, redirValid, flush;
    logic [31:0] trapMepc, trapMcause, redirAddr;
    logic        unusedBits;

    assign takeIrq  = interrupt_pending & mie;
    assign trapBase = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign irqTarget  = (mtvec[1:0] == 2'b01)
                      ? trapBase + {25'd0, interrupt_cause[4:0], 2'b00}
                      : trapBase;
    assign unusedBits = ^interrupt_cause[31:5];
`else
    assign irqTarget  = trapBase;
    assign unusedBits = ^{interrupt_cause[31:5], mtvec[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= 32'd0;
            cause_q      <= 32'd0;
            target_q     <= 32'd0;
            mieSampled_q <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cause_q      <= cause_d;
            target_q     <= target_d;
            mieSampled_q <= mieSampled_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cause_d      = cause_q;
        target_d     = target_q;
        mieSampled_d = mieSampled_q;
        count_d      = count_q;
        csrWe        = 1'b0;
        mstatusWe    = 1'b0;
        mieNext      = 1'b0;
        mpieNext     = 1'b0;
        stall        = 1'b0;
        redirValid   = 1'b0;
        flush        = 1'b0;
        trapMepc     = 32'd0;
        trapMcause   = 32'd0;
        redirAddr    = 32'd0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (takeIrq) begin
                        state_d      = SAVE;
                        pc_d         = pc_in;
                        cause_d      = {1'b1, 26'd0, interrupt_cause[4:0]};
                        target_d     = irqTarget;
                        mieSampled_d = mie;
                    end else if (ecall_in) begin
                        state_d      = SAVE;
                        pc_d         = pc_in;
                        cause_d      = 32'd11;
                        target_d     = trapBase;
                        mieSampled_d = mie;
                    end else if (ebreak_in) begin
                        state_d      = SAVE;
                        pc_d         = pc_in;
                        cause_d      = 32'd3;
                        target_d     = trapBase;
                        mieSampled_d = mie;
                    end else if (mret_in) begin
                        state_d  = RESTORE;
                        target_d = mepc;
                    end
                end
            end
            SAVE: begin
                csrWe      = 1'b1;
                mstatusWe  = 1'b1;
                trapMepc   = pc_q;
                trapMcause = cause_q;
                mieNext    = 1'b0;
                mpieNext   = mieSampled_q;
                stall      = 1'b1;
                state_d    = REDIRECT;
            end
            RESTORE: begin
                mstatusWe = 1'b1;
                mieNext   = mpie;
                mpieNext  = 1'b1;
                stall     = 1'b1;
                state_d   = REDIRECT;
            end
            REDIRECT: begin
                stall      = 1'b1;
                redirValid = 1'b1;
                redirAddr  = target_q;
                if (redirect_ready) begin
                    flush   = 1'b1;
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while rst_n is asserted so an abandoned trap never writes CSRs or flushes.
    assign csr_trap_we    = rst_n & csrWe;
    assign mstatus_we     = rst_n & mstatusWe;
    assign mie_next       = rst_n & mieNext;
    assign mpie_next      = rst_n & mpieNext;
    assign stall_pipeline = rst_n & stall;
    assign redirect_valid = rst_n & redirValid;
    assign flush_pipeline = rst_n & flush;
    assign trap_mepc      = rst_n ? trapMepc   : 32'd0;
    assign trap_mcause    = rst_n ? trapMcause : 32'd0;
    assign redirect_addr  = rst_n ? redirAddr  : 32'd0;
    assign trap_count     = rst_n ? count_q    : 16'd0;

endmodule
